// File: rtl/memory_board_ctrl.sv
// Game sequencer for the 4x4 memory-card board: pair picks, match/mismatch handling, scoring.
// Optional MEMBOARD_VSYNC_EN presents face_up/matched through a frame_start-latched shadow.
module memory_board_ctrl #(
    // Position p holds pair ID (p mod 8), so positions p and p+8 form a pair.
    parameter logic [47:0] LAYOUT      = 48'hFAC688_FAC688,
    parameter int unsigned HIDE_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sel_pos,
    input  logic        sel_valid,
    input  logic        restart,
    input  logic        frame_start,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic        busy,
    output logic [3:0]  pairs,
    output logic [7:0]  attempts,
    output logic        game_done
);
    localparam int CW = $clog2(HIDE_CYCLES + 1);

    typedef enum logic [2:0] {PICK1, PICK2, COMPARE, MISMATCH_HOLD, DONE} state_t;

    state_t         state, state_n;
    logic [3:0]     first_pos, first_pos_n, second_pos, second_pos_n;
    logic [15:0]    face_q, face_n, match_q, match_n;
    logic [3:0]     pairs_q, pairs_n;
    logic [7:0]     attempts_q, attempts_n;
    logic [CW-1:0]  hold_cnt, hold_cnt_n;
    logic           busy_q, busy_n, done_q, done_n;
    logic           pick_ok;
    logic [2:0]     pair_id [16];

    for (genvar g = 0; g < 16; g++) begin : g_ids
        assign pair_id[g] = LAYOUT[3*g+2 : 3*g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PICK1;
            first_pos  <= '0;
            second_pos <= '0;
            face_q     <= '0;
            match_q    <= '0;
            pairs_q    <= '0;
            attempts_q <= '0;
            hold_cnt   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            first_pos  <= first_pos_n;
            second_pos <= second_pos_n;
            face_q     <= face_n;
            match_q    <= match_n;
            pairs_q    <= pairs_n;
            attempts_q <= attempts_n;
            hold_cnt   <= hold_cnt_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    assign pick_ok = sel_valid && (state == PICK1 || state == PICK2)
                     && !face_q[sel_pos] && !match_q[sel_pos];

    always_comb begin
        state_n      = state;
        first_pos_n  = first_pos;
        second_pos_n = second_pos;
        face_n       = face_q;
        match_n      = match_q;
        pairs_n      = pairs_q;
        attempts_n   = attempts_q;
        hold_cnt_n   = '0;
        if (restart) begin
            state_n    = PICK1;
            face_n     = '0;
            match_n    = '0;
            pairs_n    = '0;
            attempts_n = '0;
        end else begin
            case (state)
                PICK1: if (pick_ok) begin
                    first_pos_n     = sel_pos;
                    face_n[sel_pos] = 1'b1;
                    state_n         = PICK2;
                end
                PICK2: if (pick_ok) begin
                    second_pos_n    = sel_pos;
                    face_n[sel_pos] = 1'b1;
                    if (attempts_q != 8'hFF)
                        attempts_n = attempts_q + 8'd1;
                    state_n = COMPARE;
                end
                COMPARE: begin
                    if (pair_id[first_pos] == pair_id[second_pos]) begin
                        match_n[first_pos]  = 1'b1;
                        match_n[second_pos] = 1'b1;
                        pairs_n = pairs_q + 4'd1;
                        state_n = (pairs_q == 4'd7) ? DONE : PICK1;
                    end else begin
                        hold_cnt_n = CW'(HIDE_CYCLES - 1);
                        state_n    = MISMATCH_HOLD;
                    end
                end
                MISMATCH_HOLD: begin
                    if (hold_cnt == '0) begin
                        face_n[first_pos]  = 1'b0;
                        face_n[second_pos] = 1'b0;
                        state_n = PICK1;
                    end else begin
                        hold_cnt_n = hold_cnt - CW'(1);
                    end
                end
                DONE: begin
                    face_n  = '1;
                    match_n = '1;
                end
                default: state_n = PICK1;
            endcase
        end
        busy_n = (state_n == COMPARE) || (state_n == MISMATCH_HOLD) || (state_n == DONE);
        done_n = (state_n == DONE);
    end

    assign busy      = busy_q;
    assign game_done = done_q;
    assign pairs     = pairs_q;
    assign attempts  = attempts_q;

`ifdef MEMBOARD_VSYNC_EN
    logic [15:0] face_sh, match_sh;

    // Restart blanks the display at once rather than waiting for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            face_sh  <= '0;
            match_sh <= '0;
        end else if (restart) begin
            face_sh  <= '0;
            match_sh <= '0;
        end else if (frame_start) begin
            face_sh  <= face_q;
            match_sh <= match_q;
        end
    end

    assign face_up = face_sh;
    assign matched = match_sh;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign face_up = face_q;
    assign matched = match_q;
`endif

endmodule
